alu_op_sequencer: RTL and testbench

Parametrised control sequencer for the single-bus datapath. It generates the per-step control strobes for fetch plus register-register ALU instructions (T0–T5) that the datapath benches otherwise drive by hand. It adds memory wait-state stalling, continuous-run operation, illegal-instruction detection and an instruction counter. It sits between the memory/run control and the `datapath` control inputs; the IR contents feed back in for decode.

---
 rtl/alu_op_sequencer_pkg.sv | 36 +++
 rtl/alu_op_sequencer_onehot_dec.sv | 24 ++
 rtl/alu_op_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: the control-step states,
// the opcode map and a small range-check helper.
package alu_seq_pkg;

  // One state per control step of a fetch plus register-register ALU instruction
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_TRAP
  } state_t;

  localparam int OPC_ADD = 0;
  localparam int OPC_SUB = 1;
  localparam int OPC_AND = 2;
  localparam int OPC_OR  = 3;
  localparam int OPC_SHR = 4;
  localparam int OPC_SHL = 5;
  localparam int OPC_ROR = 6;
  localparam int OPC_ROL = 7;

  // Highest opcode the datapath ALU implements; anything above traps
  localparam int OPC_LEGAL_MAX = OPC_ROL;

  // True when an index addresses one of 'limit' entries. The comparison is
  // done on int so that it stays meaningful when the field is wider than
  // the number of registers it has to address.
  function automatic logic idx_in_range(input int idx, input int limit);
    return idx < limit;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_onehot_dec.sv
// Index to one-hot decoder with a range-valid flag, used to build the
// register bus-enable and register load-enable vectors.
module onehot_dec
  import alu_seq_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N-1:0]     onehot,
  output logic             valid
);

  // Flag indices that name a register that does not exist
  always_comb valid = idx_in_range(int'(idx), N);

  // Drive at most one bit, and only for an enabled, in-range index
  always_comb begin
    onehot = '0;
    if (en && valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control sequencer for the single-bus datapath: steps through fetch and a
// register-register ALU operation, stalls on memory, traps on bad
// instructions and counts retired instructions.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = $clog2(NUM_REGS),
  parameter int OPC_W     = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 run,
  input  logic                 mem_ready,
  input  logic [DATA_W-1:0]    ir,
  output logic                 PCout,
  output logic                 MARin,
  output logic                 IncPC,
  output logic                 Zin,
  output logic                 Zlowout,
  output logic                 PCin,
  output logic                 Read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Yin,
  output logic [NUM_REGS-1:0]  reg_out,
  output logic [NUM_REGS-1:0]  reg_in,
  output logic [OPC_W-1:0]     alu_op,
  output logic                 alu_en,
  output logic                 busy,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instr_count
);

  localparam int RA_MSB  = DATA_W - 1 - OPC_W;
  localparam int RB_MSB  = RA_MSB - REG_IDX_W;
  localparam int RC_MSB  = RB_MSB - REG_IDX_W;
  localparam int LOW_MSB = RC_MSB - REG_IDX_W;

  state_t state;
  state_t next_state;

  logic [OPC_W-1:0]     ir_opc;
  logic [REG_IDX_W-1:0] ir_ra;
  logic [REG_IDX_W-1:0] ir_rb;
  logic [REG_IDX_W-1:0] ir_rc;
  logic                 unused_ir_bits;

  logic [OPC_W-1:0]     dec_opc;
  logic [REG_IDX_W-1:0] dec_ra;
  logic [REG_IDX_W-1:0] dec_rc;

  logic [REG_IDX_W-1:0] src_idx;
  logic [REG_IDX_W-1:0] dst_idx;
  logic                 src_en;
  logic                 dst_en;
  logic                 src_valid;
  logic                 dst_valid;
  logic                 instr_legal;

  assign ir_opc         = ir[DATA_W-1 -: OPC_W];
  assign ir_ra          = ir[RA_MSB -: REG_IDX_W];
  assign ir_rb          = ir[RB_MSB -: REG_IDX_W];
  assign ir_rc          = ir[RC_MSB -: REG_IDX_W];
  assign unused_ir_bits = ^ir[LOW_MSB:0];

  // During T3 both decoders look at the live IR so their valid flags double
  // as the rb/ra range checks; afterwards they use the captured fields.
  always_comb begin
    src_idx = (state == ST_T3) ? ir_rb : dec_rc;
    dst_idx = (state == ST_T3) ? ir_ra : dec_ra;
    src_en  = ((state == ST_T3) && instr_legal) || (state == ST_T4);
    dst_en  = (state == ST_T5);
  end

  // An instruction is legal when the opcode is implemented and every
  // register field names an existing register
  always_comb begin
    instr_legal = (int'(ir_opc) <= OPC_LEGAL_MAX) && src_valid && dst_valid &&
                  idx_in_range(int'(ir_rc), NUM_REGS);
  end

  onehot_dec #(.N(NUM_REGS), .IDX_W(REG_IDX_W)) u_src_dec (
    .idx    (src_idx),
    .en     (src_en),
    .onehot (reg_out),
    .valid  (src_valid)
  );

  onehot_dec #(.N(NUM_REGS), .IDX_W(REG_IDX_W)) u_dst_dec (
    .idx    (dst_idx),
    .en     (dst_en),
    .onehot (reg_in),
    .valid  (dst_valid)
  );

  // Control-step register; reset lands in IDLE from any step, even a stall
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Step sequencing; run only matters in IDLE and at the end of T5
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (run) next_state = ST_T0;
      ST_T0:   next_state = ST_T1;
      ST_T1:   if (mem_ready) next_state = ST_T2;
      ST_T2:   next_state = ST_T3;
      ST_T3:   next_state = instr_legal ? ST_T4 : ST_TRAP;
      ST_T4:   next_state = ST_T5;
      ST_T5:   next_state = run ? ST_T0 : ST_IDLE;
      ST_TRAP: next_state = ST_TRAP;
      default: next_state = ST_IDLE;
    endcase
  end

  // Per-step datapath strobes, decoded from the current step only
  always_comb begin
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    alu_en  = 1'b0;
    alu_op  = '0;
    busy    = (state != ST_IDLE);
    case (state)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: Yin = instr_legal;
      ST_T4: begin
        Zin    = 1'b1;
        alu_en = 1'b1;
        alu_op = dec_opc;
      end
      ST_T5:   Zlowout = 1'b1;
      default: ;
    endcase
  end

  // Capture the decode at the end of T3 so IR may change afterwards; flag
  // bad instructions stickily and count each completed T5
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      dec_opc     <= '0;
      dec_ra      <= '0;
      dec_rc      <= '0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (state == ST_T3) begin
        if (instr_legal) begin
          dec_opc <= ir_opc;
          dec_ra  <= ir_ra;
          dec_rc  <= ir_rc;
        end else begin
          illegal <= 1'b1;
        end
      end
      if (state == ST_T5) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a step-level model of the
// expected strobes is compared against the DUT on every cycle, alongside
// hand-computed expectations for the directed scenarios.
module tb_alu_op_sequencer;

  localparam int NUM_REGS = 16;

  localparam int P_IDLE = 0;
  localparam int P_T0   = 1;
  localparam int P_T1   = 2;
  localparam int P_T2   = 3;
  localparam int P_T3   = 4;
  localparam int P_T4   = 5;
  localparam int P_T5   = 6;
  localparam int P_TRAP = 7;

  localparam logic [31:0] IR_AND = 32'h1091_8000;
  localparam logic [31:0] IR_OR  = 32'h1891_8000;
  localparam logic [31:0] IR_ADD = 32'h022B_0000;
  localparam logic [31:0] IR_SUB = 32'h0BC4_8000;
  localparam logic [31:0] IR_BAD = 32'hF800_0000;

  logic clock = 1'b0;
  logic clear, run, mem_ready;
  logic [31:0] ir;

  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic [15:0] reg_out, reg_in;
  logic [4:0]  alu_op;
  logic        alu_en, busy, illegal;
  logic [15:0] instr_count;

  logic w_PCout, w_MARin, w_IncPC, w_Zin, w_Zlowout, w_PCin, w_Read, w_MDRin, w_MDRout, w_IRin, w_Yin;
  logic [15:0] w_reg_out, w_reg_in;
  logic [4:0]  w_alu_op;
  logic        w_alu_en, w_busy, w_illegal;
  logic [1:0]  w_instr_count;

  logic [10:0] dutStrobes, wStrobes;

  typedef struct {
    logic [10:0] strobes;
    logic [15:0] regOut;
    logic [15:0] regIn;
    logic [4:0]  aluOp;
    logic        aluEn;
    logic        busy;
    logic        illegal;
    logic [15:0] count;
    logic [1:0]  countW;
  } expect_t;

  expect_t expected;
  int  checks = 0;
  int  errors = 0;
  bit  checkEn = 0;
  int  modelCount = 0;
  bit  modelIllegal = 0;
  int  readCycles, busyCycles;
  logic [15:0] lastT3RegOut, lastT4RegOut, lastT5RegIn;
  logic [4:0]  lastT4AluOp;
  logic [1:0]  lastStartWrap;
  logic [1:0]  wrapSeen [5];
  int          wrapWant [5] = '{1, 2, 3, 0, 1};
  bit          trapped;

  always #5 clock = ~clock;

  assign dutStrobes = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin};
  assign wStrobes   = {w_PCout, w_MARin, w_IncPC, w_Zin, w_Zlowout, w_PCin, w_Read, w_MDRin,
                       w_MDRout, w_IRin, w_Yin};

  alu_op_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op), .alu_en(alu_en),
    .busy(busy), .illegal(illegal), .instr_count(instr_count)
  );

  alu_op_sequencer #(.CNT_W(2)) dut_wrap (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(w_PCout), .MARin(w_MARin), .IncPC(w_IncPC), .Zin(w_Zin), .Zlowout(w_Zlowout),
    .PCin(w_PCin), .Read(w_Read), .MDRin(w_MDRin), .MDRout(w_MDRout), .IRin(w_IRin),
    .Yin(w_Yin), .reg_out(w_reg_out), .reg_in(w_reg_in), .alu_op(w_alu_op),
    .alu_en(w_alu_en), .busy(w_busy), .illegal(w_illegal), .instr_count(w_instr_count)
  );

  // Expected outputs for one control step of an instruction word
  function automatic expect_t modelOut(input int phase, input logic [31:0] irv);
    expect_t e;
    int opc, ra, rb, rc;
    bit legal;
    opc   = int'(irv[31:27]);
    ra    = int'(irv[26:23]);
    rb    = int'(irv[22:19]);
    rc    = int'(irv[18:15]);
    legal = (opc <= 7) && (ra < NUM_REGS) && (rb < NUM_REGS) && (rc < NUM_REGS);
    e.strobes = '0;
    e.regOut  = '0;
    e.regIn   = '0;
    e.aluOp   = '0;
    e.aluEn   = 1'b0;
    e.busy    = (phase != P_IDLE);
    e.illegal = modelIllegal;
    e.count   = 16'(modelCount);
    e.countW  = 2'(modelCount % 4);
    case (phase)
      P_T0: e.strobes = 11'b111_1000_0000;
      P_T1: e.strobes = 11'b000_0111_1000;
      P_T2: e.strobes = 11'b000_0000_0110;
      P_T3: if (legal) begin
        e.strobes = 11'b000_0000_0001;
        e.regOut  = 16'd1 << rb;
      end
      P_T4: begin
        e.strobes = 11'b000_1000_0000;
        e.regOut  = 16'd1 << rc;
        e.aluEn   = 1'b1;
        e.aluOp   = 5'(opc);
      end
      P_T5: begin
        e.strobes = 11'b000_0100_0000;
        e.regIn   = 16'd1 << ra;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
    checks++;
    if (actual !== want) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, want, $time);
    end
  endtask

  // Compare every output against the model in the middle of each cycle
  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("strobes", 32'(dutStrobes), 32'(expected.strobes));
      checkOutput("reg_out", 32'(reg_out), 32'(expected.regOut));
      checkOutput("reg_in", 32'(reg_in), 32'(expected.regIn));
      checkOutput("alu_op", 32'(alu_op), 32'(expected.aluOp));
      checkOutput("alu_en", 32'(alu_en), 32'(expected.aluEn));
      checkOutput("busy", 32'(busy), 32'(expected.busy));
      checkOutput("illegal", 32'(illegal), 32'(expected.illegal));
      checkOutput("instr_count", 32'(instr_count), 32'(expected.count));
      checkOutput("wrap_strobes", 32'(wStrobes), 32'(expected.strobes));
      checkOutput("wrap_count", 32'(w_instr_count), 32'(expected.countW));
    end
  end

  // Advance one cycle and set the expectation for the step now active
  task automatic applyStimulus(input int phase, input logic [31:0] irv);
    @(posedge clock);
    #1;
    expected = modelOut(phase, irv);
    if (Read) readCycles++;
    if (busy) busyCycles++;
  endtask

  // Drive one instruction whose T0 starts at the next clock edge
  task automatic runInstr(input logic [31:0] irv, input int stalls, input bit runAfter,
                          input bit abortT4, output bit trap);
    trap       = 1'b0;
    readCycles = 0;
    busyCycles = 0;
    applyStimulus(P_T0, irv);
    lastStartWrap = w_instr_count;
    ir        = irv;
    run       = runAfter;
    mem_ready = (stalls == 0);
    for (int s = 0; s <= stalls; s++) begin
      applyStimulus(P_T1, irv);
      mem_ready = (s == stalls);
    end
    mem_ready = 1'b1;
    applyStimulus(P_T2, irv);
    applyStimulus(P_T3, irv);
    lastT3RegOut = reg_out;
    if (irv[31:27] > 5'd7) begin
      modelIllegal = 1'b1;
      trap = 1'b1;
      return;
    end
    applyStimulus(P_T4, irv);
    lastT4RegOut = reg_out;
    lastT4AluOp  = alu_op;
    ir = 32'hFFFF_FFFF;
    if (abortT4) begin
      #2 clear = 1'b0;
      #1;
      modelCount   = 0;
      modelIllegal = 1'b0;
      expected     = modelOut(P_IDLE, irv);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_count", 32'(instr_count), 32'd0);
      checkOutput("abort_strobes", 32'(dutStrobes), 32'd0);
      checkOutput("abort_reg_out", 32'(reg_out), 32'd0);
      checkOutput("abort_alu_en", 32'(alu_en), 32'd0);
      return;
    end
    applyStimulus(P_T5, irv);
    lastT5RegIn = reg_in;
    modelCount++;
  endtask

  initial begin
    clear = 1'b0;
    run = 1'b0;
    mem_ready = 1'b1;
    ir = '0;
    #3;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_count", 32'(instr_count), 32'd0);
    checkOutput("reset_illegal", 32'(illegal), 32'd0);
    checkOutput("reset_strobes", 32'(dutStrobes), 32'd0);
    expected = modelOut(P_IDLE, '0);
    checkEn = 1'b1;
    applyStimulus(P_IDLE, '0);
    clear = 1'b1;
    applyStimulus(P_IDLE, '0);
    run = 1'b1;

    // Single AND R1,R2,R3 with run dropped right after it starts
    runInstr(IR_AND, 0, 1'b0, 1'b0, trapped);
    applyStimulus(P_IDLE, '0);
    checkOutput("and_t3_reg_out", 32'(lastT3RegOut), 32'h0004);
    checkOutput("and_t4_reg_out", 32'(lastT4RegOut), 32'h0008);
    checkOutput("and_t4_alu_op", 32'(lastT4AluOp), 32'd2);
    checkOutput("and_t5_reg_in", 32'(lastT5RegIn), 32'h0002);
    checkOutput("and_busy_cycles", 32'(busyCycles), 32'd6);
    checkOutput("and_count", 32'(instr_count), 32'd1);
    checkOutput("and_idle", 32'(busy), 32'd0);
    run = 1'b1;

    // Reset pulse in the middle of T4
    runInstr(IR_ADD, 0, 1'b1, 1'b1, trapped);
    applyStimulus(P_IDLE, '0);
    clear = 1'b1;
    run = 1'b1;

    // Five back-to-back ORs
    for (int i = 0; i < 5; i++) begin
      runInstr(IR_OR, 0, (i < 4), 1'b0, trapped);
      if (i > 0) wrapSeen[i-1] = lastStartWrap;
      checkOutput("or_period", 32'(busyCycles), 32'd6);
      checkOutput("or_alu_op", 32'(lastT4AluOp), 32'd3);
    end
    applyStimulus(P_IDLE, '0);
    wrapSeen[4] = w_instr_count;
    checkOutput("or_count", 32'(instr_count), 32'd5);
    for (int i = 0; i < 5; i++) checkOutput("wrap_sequence", 32'(wrapSeen[i]), 32'(wrapWant[i]));
    run = 1'b1;

    // Three memory wait states
    runInstr(IR_SUB, 3, 1'b0, 1'b0, trapped);
    applyStimulus(P_IDLE, '0);
    checkOutput("wait_read_cycles", 32'(readCycles), 32'd4);
    checkOutput("wait_busy_cycles", 32'(busyCycles), 32'd9);
    checkOutput("wait_alu_op", 32'(lastT4AluOp), 32'd1);
    run = 1'b1;

    // Illegal opcode traps until reset
    runInstr(IR_BAD, 0, 1'b1, 1'b0, trapped);
    for (int i = 0; i < 4; i++) applyStimulus(P_TRAP, IR_BAD);
    checkOutput("trap_illegal", 32'(illegal), 32'd1);
    checkOutput("trap_busy", 32'(busy), 32'd1);
    checkOutput("trap_count", 32'(instr_count), 32'd6);
    #2 clear = 1'b0;
    #1;
    modelCount   = 0;
    modelIllegal = 1'b0;
    expected     = modelOut(P_IDLE, '0);
    checkOutput("trap_reset_illegal", 32'(illegal), 32'd0);
    checkOutput("trap_reset_busy", 32'(busy), 32'd0);
    run = 1'b0;
    applyStimulus(P_IDLE, '0);
    clear = 1'b1;
    applyStimulus(P_IDLE, '0);
    applyStimulus(P_IDLE, '0);
    #2 checkEn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
